// File: rtl/sid_wave.sv
// sid_wave: SID voice waveform generator (triangle, saw, pulse, noise, AND-mix, sync/MSB taps).
// Define SID_WAVE_NOISE_WRITEBACK_EN to let the mixed output clear LFSR taps (noise lock-up).
module sid_wave #(
    parameter int          ACC_W      = 24,
    parameter int          OUT_W      = 12,
    parameter logic [22:0] NOISE_SEED = 23'h7FFFF8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] acc_in,
    input  logic [7:0]       ctrl,
    input  logic [OUT_W-1:0] pw,
    input  logic             ring_msb_in,
    output logic [OUT_W-1:0] wave_out,
    output logic             msb_out,
    output logic             sync_out
);
    logic             msb_q, b19_q, m, shift;
    logic [22:0]      lfsr_q, lfsr_d, lfsr_sh;
    logic [OUT_W-1:0] saw, tri_w, pulse, noise, mix, wave_d;
    logic             unused;

    assign unused = ^{ctrl[1:0], acc_in[11:0]};

    always_comb begin
        m       = acc_in[23] ^ (ctrl[2] & ring_msb_in);
        saw     = acc_in[23:12];
        tri_w   = {m ? ~acc_in[22:12] : acc_in[22:12], 1'b0};
        pulse   = (ctrl[3] | (acc_in[23:12] >= pw)) ? '1 : '0;
        noise   = {lfsr_q[20], lfsr_q[18], lfsr_q[14], lfsr_q[11],
                   lfsr_q[9], lfsr_q[5], lfsr_q[2], lfsr_q[0], 4'b0000};
        mix     = (ctrl[7] ? noise : '1) & (ctrl[6] ? pulse : '1) &
                  (ctrl[5] ? saw : '1) & (ctrl[4] ? tri_w : '1);
        wave_d  = |ctrl[7:4] ? mix : '0;
        shift   = acc_in[19] & ~b19_q;
        lfsr_sh = {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};
`ifdef SID_WAVE_NOISE_WRITEBACK_EN
        // Combined noise+other waveforms pull the output taps low and feed that back
        if (ctrl[7] & |ctrl[6:4]) begin
            lfsr_sh[20] = lfsr_sh[20] & wave_d[11];
            lfsr_sh[18] = lfsr_sh[18] & wave_d[10];
            lfsr_sh[14] = lfsr_sh[14] & wave_d[9];
            lfsr_sh[11] = lfsr_sh[11] & wave_d[8];
            lfsr_sh[9]  = lfsr_sh[9]  & wave_d[7];
            lfsr_sh[5]  = lfsr_sh[5]  & wave_d[6];
            lfsr_sh[2]  = lfsr_sh[2]  & wave_d[5];
            lfsr_sh[0]  = lfsr_sh[0]  & wave_d[4];
        end
`endif
        lfsr_d  = ctrl[3] ? NOISE_SEED : (shift ? lfsr_sh : lfsr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wave_out <= '0;
            msb_out  <= 1'b0;
            sync_out <= 1'b0;
            msb_q    <= 1'b0;
            b19_q    <= 1'b0;
            lfsr_q   <= NOISE_SEED;
        end else begin
            wave_out <= wave_d;
            msb_out  <= acc_in[23];
            sync_out <= acc_in[23] & ~msb_q;
            msb_q    <= acc_in[23];
            b19_q    <= acc_in[19];
            lfsr_q   <= lfsr_d;
        end
    end
endmodule

// File: tb/tb_sid_wave.sv
// tb_sid_wave: randomized and directed checks of sid_wave against an arithmetic reference model.
module tb_sid_wave;
    localparam int SEED = 'h7FFFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] acc_in;
    logic [7:0]  ctrl;
    logic [11:0] pw;
    logic        ring_msb_in;
    logic [11:0] wave_out;
    logic        msb_out, sync_out;

    int          n_checks = 0;
    int          n_fail = 0;
    int          m_lfsr;
    bit          m_msb, m_b19;
    logic [11:0] exp_wave;
    logic        exp_msb, exp_sync;
    int          noise_pos[8] = '{20, 18, 14, 11, 9, 5, 2, 0};

    sid_wave dut (
        .clk(clk), .rst(rst), .acc_in(acc_in), .ctrl(ctrl), .pw(pw),
        .ring_msb_in(ring_msb_in), .wave_out(wave_out), .msb_out(msb_out), .sync_out(sync_out)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model_wave(logic [23:0] a, logic [7:0] c, logic [11:0] p, logic r, int l);
        int top, x, w, n;
        int comp[4];
        bit mm;
        top = int'(a >> 12);
        x   = top % 2048;
        mm  = a[23] ^ (c[2] & r);
        n   = 0;
        for (int i = 0; i < 8; i++)
            if (((l >> noise_pos[i]) & 1) == 1) n += 1 << (11 - i);
        comp[0] = mm ? 'hFFE - 2 * x : 2 * x;
        comp[1] = top;
        comp[2] = (c[3] || top >= int'(p)) ? 'hFFF : 0;
        comp[3] = n;
        if (c[7:4] == 4'd0) return 12'h000;
        w = 'hFFF;
        for (int i = 0; i < 4; i++)
            if (c[4 + i]) w &= comp[i];
        return w[11:0];
    endfunction

    // Drives one cycle of inputs, advances the reference model, and waits until outputs settle.
    task automatic step(input logic r, input logic [23:0] a, input logic [7:0] c,
                        input logic [11:0] p, input logic rg);
        rst = r; acc_in = a; ctrl = c; pw = p; ring_msb_in = rg;
        if (r) begin
            exp_wave = 0; exp_msb = 0; exp_sync = 0;
            m_msb = 0; m_b19 = 0; m_lfsr = SEED;
        end else begin
            exp_wave = model_wave(a, c, p, rg, m_lfsr);
            exp_sync = a[23] && !m_msb;
            exp_msb  = a[23];
            if (c[3]) m_lfsr = SEED;
            else if (a[19] && !m_b19) begin
                int s;
                s = ((m_lfsr * 2) % (1 << 23)) + (((m_lfsr >> 22) ^ (m_lfsr >> 17)) & 1);
`ifdef SID_WAVE_NOISE_WRITEBACK_EN
                if (c[7] && c[6:4] != 3'd0)
                    for (int i = 0; i < 8; i++)
                        if (!exp_wave[11 - i]) s &= ~(1 << noise_pos[i]);
`endif
                m_lfsr = s;
            end
            m_msb = a[23];
            m_b19 = a[19];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1, 24'hABCDEF, 8'h20, 12'h0, 1'b0);
        step(1, 24'hABCDEF, 8'h20, 12'h0, 1'b0);
        n_checks++;
        if ({wave_out, msb_out, sync_out} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wave=%h msb=%b sync=%b, expected all zero", wave_out, msb_out, sync_out);
        end
        step(0, 24'hABCDEF, 8'h20, 12'h0, 1'b0);
        n_checks++;
        if (wave_out !== 12'hABC) begin
            n_fail++;
            $display("FAIL reset_release_saw: got %h expected abc", wave_out);
        end
        step(1, 24'h0, 8'h80, 12'h0, 1'b0);
        step(0, 24'h0, 8'h80, 12'h0, 1'b0);
        n_checks++;
        if (wave_out !== 12'hFC0) begin
            n_fail++;
            $display("FAIL reset_seed_noise: got %h expected fc0", wave_out);
        end
    endtask

    task automatic test_triangle;
        logic [23:0] a[3]  = '{24'h400000, 24'hC00000, 24'h400000};
        logic [7:0]  c[3]  = '{8'h10, 8'h10, 8'h14};
        logic        rg[3] = '{1'b0, 1'b0, 1'b1};
        logic [11:0] e[3]  = '{12'h800, 12'h7FE, 12'h7FE};
        for (int i = 0; i < 3; i++) begin
            step(0, a[i], c[i], 12'h0, rg[i]);
            n_checks++;
            if (wave_out !== e[i]) begin
                n_fail++;
                $display("FAIL triangle_%0d: got %h expected %h", i, wave_out, e[i]);
            end
        end
    endtask

    task automatic test_pulse;
        logic [23:0] a[6] = '{24'h7FF000, 24'h800000, 24'h000000, 24'h000000, 24'hFFF000, 24'hFFE000};
        logic [7:0]  c[6] = '{8'h40, 8'h40, 8'h48, 8'h40, 8'h40, 8'h40};
        logic [11:0] p[6] = '{12'h800, 12'h800, 12'h800, 12'h000, 12'hFFF, 12'hFFF};
        logic [11:0] e[6] = '{12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000};
        for (int i = 0; i < 6; i++) begin
            step(0, a[i], c[i], p[i], 1'b0);
            n_checks++;
            if (wave_out !== e[i]) begin
                n_fail++;
                $display("FAIL pulse_%0d: got %h expected %h", i, wave_out, e[i]);
            end
        end
    endtask

    task automatic test_sync;
        logic [23:0] a[6] = '{24'h000000, 24'h7FFFF0, 24'h800010, 24'h900000, 24'hFFFFFF, 24'h000000};
        logic [1:0]  e[6] = '{2'b00, 2'b00, 2'b11, 2'b01, 2'b01, 2'b00};
        for (int i = 0; i < 6; i++) begin
            step(0, a[i], 8'h00, 12'h0, 1'b0);
            n_checks++;
            if ({sync_out, msb_out} !== e[i]) begin
                n_fail++;
                $display("FAIL sync_%0d: got sync=%b msb=%b expected sync=%b msb=%b",
                         i, sync_out, msb_out, e[i][1], e[i][0]);
            end
        end
    endtask

    task automatic test_noise;
        step(0, 24'h0, 8'h80, 12'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(0, (i % 2 == 0) ? 24'h080000 : 24'h0, 8'h80, 12'h0, 1'b0);
            n_checks++;
            if (wave_out !== exp_wave) begin
                n_fail++;
                $display("FAIL noise_shift_%0d: got %h expected %h", i, wave_out, exp_wave);
            end
        end
        step(0, 24'h0, 8'h88, 12'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(0, (i % 2 == 0) ? 24'h080000 : 24'h0, 8'h88, 12'h0, 1'b0);
            n_checks++;
            if (wave_out !== 12'hFC0) begin
                n_fail++;
                $display("FAIL noise_test_hold_%0d: got %h expected fc0", i, wave_out);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(0, (i % 2 == 0) ? 24'h080000 : 24'h0, 8'h80, 12'h0, 1'b0);
            n_checks++;
            if (wave_out !== exp_wave) begin
                n_fail++;
                $display("FAIL noise_resume_%0d: got %h expected %h", i, wave_out, exp_wave);
            end
        end
    endtask

    task automatic test_mix;
        logic [23:0] a[3] = '{24'h400000, 24'h400000, 24'h900000};
        logic [7:0]  c[3] = '{8'h30, 8'h00, 8'h60};
        logic [11:0] e[3] = '{12'h000, 12'h000, 12'h900};
        for (int i = 0; i < 3; i++) begin
            step(0, a[i], c[i], 12'h800, 1'b0);
            n_checks++;
            if (wave_out !== e[i]) begin
                n_fail++;
                $display("FAIL mix_%0d: got %h expected %h", i, wave_out, e[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] c;
        for (int i = 0; i < 600; i++) begin
            c = 8'($urandom);
            if ($urandom_range(0, 3) != 0) c[3] = 1'b0;
            step($urandom_range(0, 59) == 0, 24'($urandom), c, 12'($urandom), 1'($urandom));
            n_checks++;
            if ({wave_out, msb_out, sync_out} !== {exp_wave, exp_msb, exp_sync}) begin
                n_fail++;
                $display("FAIL random_%0d: got wave=%h msb=%b sync=%b expected wave=%h msb=%b sync=%b",
                         i, wave_out, msb_out, sync_out, exp_wave, exp_msb, exp_sync);
            end
        end
    endtask

    initial begin
        test_reset;
        test_triangle;
        test_pulse;
        test_sync;
        test_noise;
        test_mix;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sid_wave.md
Name: sid_wave

Overview:
- Waveform generator for one SID voice. Sits directly downstream of the 24-bit phase accumulator and consumes its value every cycle.
- Produces the 12-bit voice waveform: triangle, sawtooth, pulse, noise, or an AND-combination of the selected ones.
- Also produces the hard-sync pulse and the MSB tap that neighbouring voices use for sync and ring modulation.
- Runs in the 1 MHz voice clock domain.

Parameters:
- ACC_W, 24, accumulator width. Only 24 is supported; the bit indices below assume 24.
- OUT_W, 12, waveform output width.
- NOISE_SEED, 23'h7FFFF8, LFSR value loaded on reset and while test is set.

Ports:
- clk  in  1  voice clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- acc_in  in  24  phase accumulator value.
- ctrl  in  8  voice control: [7] noise, [6] pulse, [5] saw, [4] tri, [3] test, [2] ring, [1] sync (unused here), [0] gate (unused here).
- pw  in  12  pulse width threshold.
- ring_msb_in  in  1  acc MSB of the modulating voice.
- wave_out  out  12  registered waveform sample.
- msb_out  out  1  registered acc_in[23], for neighbour voices.
- sync_out  out  1  one-cycle pulse on an acc_in[23] rising edge.

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous and active-high.
- Reset values: wave_out=0, msb_out=0, sync_out=0, msb_q=0, b19_q=0, lfsr=NOISE_SEED.
- Latency: wave_out, msb_out and sync_out are registered, so they reflect acc_in, ctrl, pw and ring_msb_in from the previous cycle.
- Edge detect: msb_q <= acc_in[23] and b19_q <= acc_in[19] every cycle.
  - sync_out <= acc_in[23] & ~msb_q.
  - msb_out <= acc_in[23].
- Noise LFSR (23 bits):
  - If ctrl[3]=1: lfsr <= NOISE_SEED (held).
  - Else if acc_in[19] & ~b19_q: lfsr <= {lfsr[21:0], lfsr[22]^lfsr[17]}.
  - Otherwise hold.
- Component waveforms are computed combinationally from the current-cycle inputs and the pre-update lfsr:
  - saw = acc_in[23:12].
  - tri: m = acc_in[23] ^ (ctrl[2] & ring_msb_in). tri = {(m ? ~acc_in[22:12] : acc_in[22:12]), 1'b0}.
  - pulse = (ctrl[3] | (acc_in[23:12] >= pw)) ? 12'hFFF : 12'h000. pw=0 gives constant FFF; pw=FFF gives FFF only at acc_in[23:12]=FFF.
  - noise = {lfsr[20], lfsr[18], lfsr[14], lfsr[11], lfsr[9], lfsr[5], lfsr[2], lfsr[0], 4'b0000}.
- Mixing:
  - wave_out <= bitwise AND of all selected components (ctrl[7:4]).
  - No component selected gives 12'h000.
- Boundary conditions:
  - Accumulator wrap FFFFFF->000000 gives no sync pulse (MSB falling).
  - A jump from 7FFFFF to 800000 gives exactly one sync pulse.
  - acc_in[23] held high gives no repeat pulse.
- Test bit: ctrl[3] forces pulse high and pins the LFSR at seed while set. Clearing ctrl[3] resumes shifting on the next bit-19 rising edge.
- ctrl and pw changes take effect on the next registered sample; no pipelining of control.
- rst mid-operation overrides all updates in that cycle.

Optional Feature:
- Macro: SID_WAVE_NOISE_WRITEBACK_EN.
- Defined:
  - Applies when ctrl[7]=1 and any of ctrl[6:4]=1, on an LFSR shift cycle.
  - The shifted value's bits at positions {20,18,14,11,9,5,2,0} are ANDed with the corresponding next wave_out[11:4] bits before being stored.
  - This models noise lock-up.
- Undefined: the LFSR is never modified by the output; behaviour is exactly as above.

Test Plan:
- rst=1 for 2 cycles with acc_in=24'hABCDEF and ctrl=8'h20 -> wave_out=0, sync_out=0, lfsr=7FFFF8. The cycle after rst drops, wave_out=12'hABC.
- ctrl=8'h10, acc_in=24'h400000 -> wave_out=12'h800. acc_in=24'hC00000 -> wave_out=12'h7FE. With ring set, ring_msb_in=1 and acc_in=24'h400000 -> 12'h7FE.
- ctrl=8'h40, pw=12'h800: acc_in=24'h7FF000 -> 12'h000; acc_in=24'h800000 -> 12'hFFF. Setting test (ctrl=8'h48) -> 12'hFFF regardless.
- acc_in stepping 24'h7FFFF0 -> 24'h800010 -> 24'h900000 -> sync_out high for exactly one cycle, one cycle after the 800010 sample. msb_out follows acc_in[23] with 1 cycle of delay.
- ctrl=8'h80, acc_in toggling bit 19 five times -> LFSR shifts 5 times, and noise output matches the reference LFSR model sequence starting from 7FFFF8. With ctrl[3] set, no shifts occur.
- ctrl=8'h30, acc_in=24'h400000 -> wave_out = 12'h400 & 12'h800 = 12'h000. ctrl=8'h00 -> 12'h000.
